// File: rtl/shot_responder.sv
// rtl/shot_responder.sv - Battleship shot responder: synchronised KEY, 3x3 scan FSM, registered verdict
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   score_L            raw active-low KEY, asynchronous to clock
//   x, y, big          target column/row (1..BOARD_N) and big-bomb select
//   result_valid       one-cycle pulse when the verdict below is updated
//   hit/near_miss/miss verdict of the last accepted shot
//   wrong              last request rejected (off board or no big bombs left)
//   num_hits           distinct ship cells hit so far (0..17)
//   biggest_ship_hit   one-hot largest ship hit by the last shot
//   bigs_left          big bombs remaining
//   game_over          every ship cell has been hit; requests ignored until reset
module shot_responder #(
  parameter int BIG_BOMBS = 2,
  parameter int BOARD_N   = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       score_L,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       big,
  output logic       result_valid,
  output logic       hit,
  output logic       near_miss,
  output logic       miss,
  output logic       wrong,
  output logic [4:0] num_hits,
  output logic [4:0] biggest_ship_hit,
  output logic [1:0] bigs_left,
  output logic       game_over
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  localparam logic [3:0] EDGE_N    = 4'(BOARD_N);
  localparam logic [1:0] BIGS_INIT = 2'(BIG_BOMBS);

  logic        sync1, sync2, hist;
  logic [1:0]  state;
  logic [3:0]  xr, yr;
  logic        bigr;
  logic [3:0]  idx;
  logic [16:0] hmap;        // one bit per ship cell, set once that cell is hit
  logic        any_mark, near_flag;
  logic [4:0]  ships_mask;  // ships that lost a cell during the current shot

  logic        start, wrong_c;
  logic [3:0]  dx_off, dy_off, cx, cy;
  logic        on_board, cell_ship;
  logic [4:0]  cell_bit;
  logic [2:0]  cell_idx;
  logic        scan_active, centre, unhit, mark_now, near_now;
  logic        any_mark_n, near_n;
  logic [4:0]  mask_n, top_ship;

  assign start   = hist & ~sync2 & (state == IDLE) & ~game_over;
  assign wrong_c = (xr == 4'd0) | (xr > EDGE_N) | (yr == 4'd0) | (yr > EDGE_N)
                 | (bigr & (bigs_left == 2'd0));

  // idx walks the 3x3 neighbourhood row-major; offsets are 0..2 around (x-1, y-1).
  always_comb begin
    dy_off = 4'd0;
    if (idx >= 4'd6)      dy_off = 4'd2;
    else if (idx >= 4'd3) dy_off = 4'd1;
    dx_off = idx - (dy_off << 1) - dy_off;
  end

  assign cx       = xr + dx_off - 4'd1;
  assign cy       = yr + dy_off - 4'd1;
  assign on_board = (cx != 4'd0) & (cx <= EDGE_N) & (cy != 4'd0) & (cy <= EDGE_N);

  // Fixed fleet: cell_bit is the cell's slot in hmap, cell_idx the ship number.
  always_comb begin
    cell_ship = 1'b0;
    cell_bit  = 5'd0;
    cell_idx  = 3'd0;
    if (on_board) begin
      if (cy == 4'd1 && cx <= 4'd5) begin
        cell_ship = 1'b1; cell_idx = 3'd4; cell_bit = {1'b0, cx} - 5'd1;
      end else if (cx == 4'd10 && cy <= 4'd4) begin
        cell_ship = 1'b1; cell_idx = 3'd3; cell_bit = {1'b0, cy} + 5'd4;
      end else if (cy == 4'd5 && cx >= 4'd3 && cx <= 4'd5) begin
        cell_ship = 1'b1; cell_idx = 3'd2; cell_bit = {1'b0, cx} + 5'd6;
      end else if (cx == 4'd7 && cy >= 4'd7 && cy <= 4'd9) begin
        cell_ship = 1'b1; cell_idx = 3'd1; cell_bit = {1'b0, cy} + 5'd5;
      end else if (cy == 4'd10 && cx <= 4'd2) begin
        cell_ship = 1'b1; cell_idx = 3'd0; cell_bit = {1'b0, cx} + 5'd14;
      end
    end
  end

  // Cell idx 0 is visited on the CHECK exit edge, so SCAN covers idx 1..8 and
  // the verdict is loaded on the same edge that visits idx 8.
  assign scan_active = ((state == CHECK) & ~wrong_c) | (state == SCAN);
  assign centre      = (idx == 4'd4);
  assign unhit       = cell_ship & ~hmap[cell_bit];
  assign mark_now    = scan_active & unhit & (bigr | centre);
  assign near_now    = scan_active & unhit & ~bigr & ~centre;
  assign any_mark_n  = any_mark | mark_now;
  assign near_n      = near_flag | near_now;
  assign mask_n      = ships_mask | (mark_now ? (5'd1 << cell_idx) : 5'd0);

  always_comb begin
    top_ship = 5'd0;
    if (mask_n[4])      top_ship = 5'b10000;
    else if (mask_n[3]) top_ship = 5'b01000;
    else if (mask_n[2]) top_ship = 5'b00100;
    else if (mask_n[1]) top_ship = 5'b00010;
    else if (mask_n[0]) top_ship = 5'b00001;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1            <= 1'b1;
      sync2            <= 1'b1;
      hist             <= 1'b1;
      state            <= IDLE;
      xr               <= 4'd0;
      yr               <= 4'd0;
      bigr             <= 1'b0;
      idx              <= 4'd0;
      hmap             <= 17'd0;
      any_mark         <= 1'b0;
      near_flag        <= 1'b0;
      ships_mask       <= 5'd0;
      result_valid     <= 1'b0;
      hit              <= 1'b0;
      near_miss        <= 1'b0;
      miss             <= 1'b0;
      wrong            <= 1'b0;
      num_hits         <= 5'd0;
      biggest_ship_hit <= 5'd0;
      bigs_left        <= BIGS_INIT;
      game_over        <= 1'b0;
    end else begin
      sync1 <= score_L;
      sync2 <= sync1;
      hist  <= sync2;

      if (mark_now) begin
        hmap[cell_bit] <= 1'b1;
        num_hits       <= num_hits + 5'd1;
        if (num_hits == 5'd16) game_over <= 1'b1;
      end
      any_mark   <= any_mark_n;
      near_flag  <= near_n;
      ships_mask <= mask_n;

      case (state)
        IDLE: begin
          if (start) begin
            xr         <= x;
            yr         <= y;
            bigr       <= big;
            idx        <= 4'd0;
            any_mark   <= 1'b0;
            near_flag  <= 1'b0;
            ships_mask <= 5'd0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (wrong_c) begin
            result_valid     <= 1'b1;
            wrong            <= 1'b1;
            hit              <= 1'b0;
            near_miss        <= 1'b0;
            miss             <= 1'b0;
            biggest_ship_hit <= 5'd0;
            state            <= REPORT;
          end else begin
            if (bigr) bigs_left <= bigs_left - 2'd1;
            idx   <= 4'd1;
            state <= SCAN;
          end
        end
        SCAN: begin
          idx <= idx + 4'd1;
          if (idx == 4'd8) begin
            result_valid     <= 1'b1;
            wrong            <= 1'b0;
            hit              <= any_mark_n;
            near_miss        <= ~any_mark_n & near_n;
            miss             <= ~any_mark_n & ~near_n;
            biggest_ship_hit <= top_ship;
            state            <= REPORT;
          end
        end
        REPORT: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_responder.sv
// tb/tb_shot_responder.sv - self-checking bench for shot_responder against a board-level model
module tb_shot_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       score_L = 1'b1;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic       big = 1'b0;
  logic       result_valid, hit, near_miss, miss, wrong, game_over;
  logic [4:0] num_hits, biggest_ship_hit;
  logic [1:0] bigs_left;

  shot_responder #(.BIG_BOMBS(2), .BOARD_N(10)) dut (
    .clock(clock), .reset(reset), .score_L(score_L), .x(x), .y(y), .big(big),
    .result_valid(result_valid), .hit(hit), .near_miss(near_miss), .miss(miss),
    .wrong(wrong), .num_hits(num_hits), .biggest_ship_hit(biggest_ship_hit),
    .bigs_left(bigs_left), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Board model: ship_of[x][y] is the ship number (4 = carrier .. 0 = destroyer) or -1.
  int ship_of [1:10][1:10];
  bit m_hit   [1:10][1:10];
  int m_hits, m_bigs;
  bit m_over;
  bit m_v_hit, m_v_near, m_v_miss, m_v_wrong;
  logic [4:0] m_v_big;

  localparam logic [16:0] RESET_VEC = {4'b0000, 5'd0, 5'd0, 2'd2, 1'b0};

  task automatic model_init();
    for (int i = 1; i <= 10; i++)
      for (int j = 1; j <= 10; j++) begin
        ship_of[i][j] = -1;
        m_hit[i][j]   = 1'b0;
      end
    for (int i = 1; i <= 5; i++) ship_of[i][1]  = 4;
    for (int i = 1; i <= 4; i++) ship_of[10][i] = 3;
    for (int i = 3; i <= 5; i++) ship_of[i][5]  = 2;
    for (int i = 7; i <= 9; i++) ship_of[7][i]  = 1;
    for (int i = 1; i <= 2; i++) ship_of[i][10] = 0;
    m_hits = 0; m_bigs = 2; m_over = 1'b0;
    m_v_hit = 0; m_v_near = 0; m_v_miss = 0; m_v_wrong = 0; m_v_big = 5'd0;
  endtask

  function automatic logic [16:0] model_vec();
    return {m_v_hit, m_v_near, m_v_miss, m_v_wrong, 5'(m_hits), m_v_big, 2'(m_bigs), m_over};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {hit, near_miss, miss, wrong, num_hits, biggest_ship_hit, bigs_left, game_over};
  endfunction

  task automatic model_shot(input int sx, input int sy, input bit sb,
                            output logic [16:0] ev, output int elat, output int epulses);
    int marked, best, cx, cy;
    bit near;
    if (m_over) begin
      elat = 0; epulses = 0;
    end else if (sx < 1 || sx > 10 || sy < 1 || sy > 10 || (sb && m_bigs == 0)) begin
      m_v_hit = 0; m_v_near = 0; m_v_miss = 0; m_v_wrong = 1; m_v_big = 5'd0;
      elat = 4; epulses = 1;
    end else begin
      if (sb) m_bigs--;
      marked = 0; best = -1; near = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          cx = sx + dx; cy = sy + dy;
          if (cx >= 1 && cx <= 10 && cy >= 1 && cy <= 10)
            if (ship_of[cx][cy] >= 0 && !m_hit[cx][cy]) begin
              if (sb || (dx == 0 && dy == 0)) begin
                m_hit[cx][cy] = 1'b1;
                marked++;
                if (ship_of[cx][cy] > best) best = ship_of[cx][cy];
              end else begin
                near = 1;
              end
            end
        end
      m_hits   += marked;
      m_v_wrong = 0;
      m_v_hit   = (marked > 0);
      m_v_near  = !m_v_hit && near && !sb;
      m_v_miss  = !m_v_hit && !m_v_near;
      m_v_big   = (best >= 0) ? 5'(1 << best) : 5'd0;
      m_over    = (m_hits == 17);
      elat = 12; epulses = 1;
    end
    ev = model_vec();
  endtask

  // Drives one KEY press; switches are scrambled after capture to show they are latched.
  task automatic fire(input logic [3:0] fx, input logic [3:0] fy, input logic fb,
                      input int repress_at, input int reset_at,
                      output int lat, output int pulses);
    @(posedge clock); #1;
    x = fx; y = fy; big = fb; score_L = 1'b0;
    lat = 0; pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock); #1;
      if (result_valid) begin
        pulses++;
        if (lat == 0) lat = e;
      end
      if (e == 3) begin x = 4'($urandom); y = 4'($urandom); big = 1'($urandom); end
      if (e == 5) score_L = 1'b1;
      if (repress_at != 0 && e == repress_at)     score_L = 1'b0;
      if (repress_at != 0 && e == repress_at + 2) score_L = 1'b1;
      if (reset_at != 0 && e == reset_at)     reset = 1'b1;
      if (reset_at != 0 && e == reset_at + 2) reset = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; score_L = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    model_init();
    n_checks++;
    if (obs_vec() !== RESET_VEC || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h rv=%b, want %h rv=0", obs_vec(), result_valid, RESET_VEC);
    end
  endtask

  task automatic test_normal_hit();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    fire(4'd3, 4'd1, 1'b0, 0, 0, lat, pulses);
    model_shot(3, 1, 0, ev, elat, ep);
    n_checks++;
    if (lat !== 12 || pulses !== 1) begin
      n_fail++; $display("FAIL normal_latency: got edge %0d pulses %0d, want 12 and 1", lat, pulses);
    end
    n_checks++;
    if (hit !== 1'b1 || num_hits !== 5'd1 || biggest_ship_hit !== 5'b10000) begin
      n_fail++; $display("FAIL normal_hit: got hit=%b n=%0d big=%b, want 1 1 10000", hit, num_hits, biggest_ship_hit);
    end
    n_checks++;
    if (obs_vec() !== ev) begin
      n_fail++; $display("FAIL normal_hit_model: got %h, want %h", obs_vec(), ev);
    end
  endtask

  task automatic test_near_miss();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    fire(4'd3, 4'd1, 1'b0, 0, 0, lat, pulses);
    model_shot(3, 1, 0, ev, elat, ep);
    n_checks++;
    if (hit !== 1'b0 || near_miss !== 1'b1 || miss !== 1'b0 || num_hits !== 5'd1) begin
      n_fail++; $display("FAIL reshoot_near: got h=%b nm=%b m=%b n=%0d, want 0 1 0 1", hit, near_miss, miss, num_hits);
    end
    n_checks++;
    if (obs_vec() !== ev || lat !== elat) begin
      n_fail++; $display("FAIL reshoot_model: got %h lat %0d, want %h lat %0d", obs_vec(), lat, ev, elat);
    end
  endtask

  task automatic test_big_bomb();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    fire(4'd4, 4'd5, 1'b1, 0, 0, lat, pulses);
    model_shot(4, 5, 1, ev, elat, ep);
    n_checks++;
    if (hit !== 1'b1 || num_hits !== 5'd4 || bigs_left !== 2'd1 || biggest_ship_hit !== 5'b00100 || lat !== 12) begin
      n_fail++; $display("FAIL big_bomb: got h=%b n=%0d bl=%0d big=%b lat=%0d, want 1 4 1 00100 12",
                         hit, num_hits, bigs_left, biggest_ship_hit, lat);
    end
    n_checks++;
    if (obs_vec() !== ev) begin
      n_fail++; $display("FAIL big_bomb_model: got %h, want %h", obs_vec(), ev);
    end
    fire(4'd8, 4'd5, 1'b0, 0, 0, lat, pulses);
    model_shot(8, 5, 0, ev, elat, ep);
    n_checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || near_miss !== 1'b0 || obs_vec() !== ev) begin
      n_fail++; $display("FAIL plain_miss: got %h, want %h", obs_vec(), ev);
    end
  endtask

  task automatic test_wrong();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    logic [3:0] wx [3] = '{4'd0, 4'd11, 4'd5};
    logic [3:0] wy [3] = '{4'd4, 4'd4, 4'd0};
    for (int i = 0; i < 3; i++) begin
      fire(wx[i], wy[i], 1'b0, 0, 0, lat, pulses);
      model_shot(int'(wx[i]), int'(wy[i]), 0, ev, elat, ep);
      n_checks++;
      if (lat !== 4 || pulses !== 1 || wrong !== 1'b1 || hit !== 1'b0 || near_miss !== 1'b0 ||
          miss !== 1'b0 || num_hits !== 5'd4 || obs_vec() !== ev) begin
        n_fail++; $display("FAIL wrong_coord_%0d: got %h lat %0d pulses %0d, want %h lat 4 pulses 1",
                           i, obs_vec(), lat, pulses, ev);
      end
    end
  endtask

  task automatic test_bigs_exhausted();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    fire(4'd5, 4'd9, 1'b1, 0, 0, lat, pulses);
    model_shot(5, 9, 1, ev, elat, ep);
    n_checks++;
    if (bigs_left !== 2'd0 || miss !== 1'b1 || obs_vec() !== ev) begin
      n_fail++; $display("FAIL second_big: got %h, want %h", obs_vec(), ev);
    end
    fire(4'd2, 4'd2, 1'b1, 0, 0, lat, pulses);
    model_shot(2, 2, 1, ev, elat, ep);
    n_checks++;
    if (wrong !== 1'b1 || bigs_left !== 2'd0 || lat !== 4 || obs_vec() !== ev) begin
      n_fail++; $display("FAIL no_bigs_left: got %h lat %0d, want %h lat 4", obs_vec(), lat, ev);
    end
  endtask

  task automatic test_press_during_scan();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    fire(4'd7, 4'd8, 1'b0, 7, 0, lat, pulses);
    model_shot(7, 8, 0, ev, elat, ep);
    n_checks++;
    if (pulses !== 1 || lat !== 12 || obs_vec() !== ev) begin
      n_fail++; $display("FAIL press_in_scan: got %h pulses %0d lat %0d, want %h pulses 1 lat 12",
                         obs_vec(), pulses, lat, ev);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    fire(4'd1, 4'd10, 1'b0, 0, 7, lat, pulses);
    model_init();
    n_checks++;
    if (pulses !== 0 || obs_vec() !== RESET_VEC || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_scan: got %h pulses %0d, want %h pulses 0", obs_vec(), pulses, RESET_VEC);
    end
    fire(4'd3, 4'd1, 1'b0, 0, 0, lat, pulses);
    model_shot(3, 1, 0, ev, elat, ep);
    n_checks++;
    if (hit !== 1'b1 || num_hits !== 5'd1 || obs_vec() !== ev) begin
      n_fail++; $display("FAIL map_cleared: got %h, want %h", obs_vec(), ev);
    end
  endtask

  task automatic test_random();
    int lat, pulses, elat, ep, sx, sy;
    bit sb;
    logic [16:0] ev;
    for (int i = 0; i < 30; i++) begin
      sx = $urandom_range(0, 11);
      sy = $urandom_range(0, 11);
      sb = ($urandom_range(0, 3) == 0);
      fire(4'(sx), 4'(sy), sb, 0, 0, lat, pulses);
      model_shot(sx, sy, sb, ev, elat, ep);
      n_checks++;
      if (obs_vec() !== ev || lat !== elat || pulses !== ep) begin
        n_fail++; $display("FAIL random_%0d (%0d,%0d,%0d): got %h lat %0d pulses %0d, want %h lat %0d pulses %0d",
                           i, sx, sy, sb, obs_vec(), lat, pulses, ev, elat, ep);
      end
    end
  endtask

  task automatic test_game_over();
    int lat, pulses, elat, ep;
    logic [16:0] ev;
    do_reset();
    model_init();
    for (int cx = 1; cx <= 10; cx++)
      for (int cy = 1; cy <= 10; cy++)
        if (ship_of[cx][cy] >= 0) begin
          fire(4'(cx), 4'(cy), 1'b0, 0, 0, lat, pulses);
          model_shot(cx, cy, 0, ev, elat, ep);
          n_checks++;
          if (obs_vec() !== ev || lat !== elat) begin
            n_fail++; $display("FAIL sink_(%0d,%0d): got %h lat %0d, want %h lat %0d", cx, cy, obs_vec(), lat, ev, elat);
          end
        end
    n_checks++;
    if (game_over !== 1'b1 || num_hits !== 5'd17) begin
      n_fail++; $display("FAIL game_over_set: got go=%b n=%0d, want 1 17", game_over, num_hits);
    end
    fire(4'd8, 4'd8, 1'b0, 0, 0, lat, pulses);
    n_checks++;
    if (pulses !== 0 || game_over !== 1'b1) begin
      n_fail++; $display("FAIL after_game_over: got pulses %0d go=%b, want 0 1", pulses, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_normal_hit();
    test_near_miss();
    test_big_bomb();
    test_wrong();
    test_bigs_exhausted();
    test_press_during_scan();
    test_reset_mid_scan();
    test_random();
    test_game_over();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
